// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller: sequences NS/EW signal heads through
// green/yellow/all-red phases and arbitrates side-road and pedestrian demand.
module traffic_phase_ctrl #(
    parameter int unsigned NBITS    = 32,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_NS_MIN = 5,
    parameter int unsigned T_EW     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] phase,
    output logic       phase_start
);

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } state_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [NBITS-1:0] CNT_ONE     = NBITS'(1);
    localparam logic [NBITS-1:0] ALLRED_LAST = NBITS'(T_ALLRED - 1);
    localparam logic [NBITS-1:0] YELLOW_LAST = NBITS'(T_YELLOW - 1);
    localparam logic [NBITS-1:0] NS_MIN_LAST = NBITS'(T_NS_MIN - 1);
    localparam logic [NBITS-1:0] EW_LAST     = NBITS'(T_EW - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic             ped_pend_q, ped_pend_d;
    logic             walk_en_q, walk_en_d;
    logic             phase_start_q, phase_start_d;
    logic             demand;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ALLRED_A;
            cnt_q         <= '0;
            ped_pend_q    <= 1'b0;
            walk_en_q     <= 1'b0;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pend_q    <= ped_pend_d;
            walk_en_q     <= walk_en_d;
            phase_start_q <= phase_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_ONE;
        ped_pend_d = ped_pend_q | ped_req;
        walk_en_d  = walk_en_q;
        demand     = ew_car | ped_pend_q | ped_req;

        case (state_q)
            ALLRED_A: begin
                if (cnt_q == ALLRED_LAST) state_d = NS_GREEN;
            end
            NS_GREEN: begin
                // Counter parks at the minimum so green can hold with no wrap.
                if (cnt_q == NS_MIN_LAST) begin
                    cnt_d = cnt_q;
                    if (demand) state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: begin
                if (cnt_q == YELLOW_LAST) state_d = ALLRED_B;
            end
            ALLRED_B: begin
                if (cnt_q == ALLRED_LAST) begin
                    state_d    = EW_GREEN;
                    walk_en_d  = ped_pend_q | ped_req;
                    ped_pend_d = 1'b0;
                end
            end
            EW_GREEN: begin
                if (cnt_q == EW_LAST) begin
                    state_d   = EW_YELLOW;
                    walk_en_d = 1'b0;
                end
            end
            EW_YELLOW: begin
                if (cnt_q == YELLOW_LAST) state_d = ALLRED_A;
            end
            default: begin
                state_d   = ALLRED_A;
                walk_en_d = 1'b0;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        phase_start_d = (state_d != state_q);
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        case (state_q)
            NS_GREEN:  ns_light = LAMP_GRN;
            NS_YELLOW: ns_light = LAMP_YEL;
            EW_GREEN:  ew_light = LAMP_GRN;
            EW_YELLOW: ew_light = LAMP_YEL;
            default:   ;
        endcase
    end

    assign walk        = walk_en_q & (state_q == EW_GREEN);
    assign phase       = state_q;
    assign phase_start = phase_start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: directed phase sequences plus a
// randomized run checked for safety, phase order and phase durations.
module tb_traffic_phase_ctrl;

    localparam logic [2:0] AA = 3'd0, NG = 3'd1, NY = 3'd2, AB = 3'd3, EG = 3'd4, EY = 3'd5;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    logic       clk = 1'b0;
    logic       reset, ew_car, ped_req;
    logic [2:0] ns_light, ew_light, phase;
    logic       walk, phase_start;

    traffic_phase_ctrl #(
        .NBITS(32), .T_ALLRED(2), .T_YELLOW(3), .T_NS_MIN(5), .T_EW(4)
    ) dut (
        .clk(clk), .reset(reset), .ew_car(ew_car), .ped_req(ped_req),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
        .phase(phase), .phase_start(phase_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ph;
        logic       wk;
        logic       ps;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          started = 1'b0;
    bit          rand_mode = 1'b0;
    logic [2:0]  prev_ph;
    int unsigned run_len;

    function automatic logic [2:0] ns_of(input logic [2:0] ph);
        return (ph == NG) ? GRN : (ph == NY) ? YEL : RED;
    endfunction

    function automatic logic [2:0] ew_of(input logic [2:0] ph);
        return (ph == EG) ? GRN : (ph == EY) ? YEL : RED;
    endfunction

    function automatic int unsigned dur_of(input logic [2:0] ph);
        case (ph)
            AA: return 2;
            NY: return 3;
            AB: return 2;
            EG: return 4;
            EY: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] next_of(input logic [2:0] ph);
        case (ph)
            AA: return NG;
            NG: return NY;
            NY: return AB;
            AB: return EG;
            EG: return EY;
            default: return AA;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (started)
            chk("safety_one_red", 32'(ns_light == RED || ew_light == RED), 32'd1);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("phase", 32'(phase), 32'(mon_e.ph));
            chk("walk", 32'(walk), 32'(mon_e.wk));
            chk("phase_start", 32'(phase_start), 32'(mon_e.ps));
            chk("ns_light", 32'(ns_light), 32'(ns_of(mon_e.ph)));
            chk("ew_light", 32'(ew_light), 32'(ew_of(mon_e.ph)));
        end
        if (!rand_mode) begin
            prev_ph = AA;
            run_len = 0;
        end else begin
            chk("walk_only_in_ew_green", 32'(walk && phase != EG), 32'd0);
            if (phase == prev_ph) begin
                run_len++;
                chk("rand_no_start_pulse", 32'(phase_start), 32'd0);
            end else begin
                chk("rand_start_pulse", 32'(phase_start), 32'd1);
                chk("rand_order", 32'(phase), 32'(next_of(prev_ph)));
                if (prev_ph == NG)
                    chk("rand_ns_green_min", 32'(run_len >= 5), 32'd1);
                else
                    chk("rand_duration", run_len, dur_of(prev_ph));
                prev_ph = phase;
                run_len = 1;
            end
        end
    end

    // One clock cycle: drive inputs, record the outputs expected during this cycle.
    task automatic step(input logic r, input logic e, input logic p, input logic c,
                        input logic [2:0] ph, input logic wk, input logic ps);
        exp_t x;
        reset   = r;
        ew_car  = e;
        ped_req = p;
        if (c) begin
            x.ph = ph;
            x.wk = wk;
            x.ps = ps;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic e, input logic p, input logic [2:0] ph,
                       input int unsigned n, input logic wk, input logic ps_first);
        for (int unsigned i = 0; i < n; i++)
            step(1'b0, e, p, 1'b1, ph, wk, (i == 0) ? ps_first : 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, AA, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ew_car = 1'b0; ped_req = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        started = 1'b1;

        // Idle: all-red 2 cycles, then NS green holds.
        seg(0, 0, AA, 2, 0, 0);
        seg(0, 0, NG, 22, 0, 1);

        // Side car present from NS green cycle 1: full sequence at minimum timing.
        do_reset();
        seg(0, 0, AA, 2, 0, 0);
        seg(1, 0, NG, 5, 0, 1);
        seg(1, 0, NY, 3, 0, 1);
        seg(1, 0, AB, 2, 0, 1);
        seg(1, 0, EG, 4, 0, 1);
        seg(1, 0, EY, 3, 0, 1);
        seg(1, 0, AA, 2, 0, 1);
        seg(0, 0, NG, 6, 0, 1);

        // Pedestrian pulse after the minimum: yellow next cycle, walk for all of EW green.
        do_reset();
        seg(0, 0, AA, 2, 0, 0);
        seg(0, 0, NG, 7, 0, 1);
        step(0, 0, 1, 1, NG, 0, 0);
        seg(0, 0, NY, 3, 0, 1);
        seg(0, 0, AB, 2, 0, 1);
        seg(0, 0, EG, 4, 1, 1);
        seg(0, 0, EY, 3, 0, 1);
        seg(0, 0, AA, 2, 0, 1);
        seg(0, 0, NG, 12, 0, 1);

        // Car drops in NS yellow; pedestrian pulse in EW green is served next cycle round.
        do_reset();
        seg(0, 0, AA, 2, 0, 0);
        seg(1, 0, NG, 5, 0, 1);
        seg(0, 0, NY, 3, 0, 1);
        seg(0, 0, AB, 2, 0, 1);
        step(0, 0, 0, 1, EG, 0, 1);
        step(0, 0, 1, 1, EG, 0, 0);
        seg(0, 0, EG, 2, 0, 0);
        seg(0, 0, EY, 3, 0, 1);
        seg(0, 0, AA, 2, 0, 1);
        seg(0, 0, NG, 5, 0, 1);
        seg(0, 0, NY, 3, 0, 1);
        seg(0, 0, AB, 2, 0, 1);
        seg(0, 0, EG, 4, 1, 1);
        seg(0, 0, EY, 3, 0, 1);
        seg(0, 0, AA, 2, 0, 1);
        seg(0, 0, NG, 8, 0, 1);

        // Reset mid EW green with a pending pedestrian request and a coincident press.
        do_reset();
        seg(0, 0, AA, 2, 0, 0);
        seg(1, 0, NG, 5, 0, 1);
        seg(0, 0, NY, 3, 0, 1);
        seg(0, 0, AB, 2, 0, 1);
        step(0, 0, 0, 1, EG, 0, 1);
        step(0, 0, 1, 1, EG, 0, 0);
        step(1, 0, 1, 1, EG, 0, 0);
        seg(0, 0, AA, 2, 0, 0);
        seg(0, 0, NG, 20, 0, 1);

        // Random demand: invariants, order and durations checked by the monitor.
        do_reset();
        rand_mode = 1'b1;
        for (int unsigned i = 0; i < 10000; i++)
            step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                 1'b0, AA, 1'b0, 1'b0);
        rand_mode = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, AA, 1'b0, 1'b0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
